// File: rtl/mem_dp48_pkg.sv
// mem_dp48 shared types: word/address sizes, clear FSM states,
// per-port write lanes and the same-word write priority.
package mem_dp48_pkg;

  localparam int SIZE_DATA = 24;
  localparam int SIZE_WORD = SIZE_DATA;
  localparam int SIZE_ADDR = 48;
  localparam int SIZE_DW   = 2 * SIZE_WORD;

  typedef enum logic {
    MEM_ST_CLR = 1'b0,
    MEM_ST_RUN = 1'b1
  } mem_st_e;

  // Port whose write lands when both ports hit the same word.
  localparam int MEM_WR_PRIO = 1;

  typedef struct packed {
    logic lo;
    logic hi;
  } wr_lane_t;

  function automatic logic [SIZE_DW-1:0] pack48(
    input logic [SIZE_WORD-1:0] hi,
    input logic [SIZE_WORD-1:0] lo
  );
    return {hi, lo};
  endfunction

endpackage

// File: rtl/mem_dp48_if.sv
// mem_dp48 MA/MO memory-port bundle, two ports plus ready.
// master drives addresses/writes, slave is the memory.
interface mem_dp48_if;
  import mem_dp48_pkg::*;

  logic                 iw_addr_v [2];
  logic [SIZE_ADDR-1:0] iw_addr   [2];
  logic                 iw_we     [2];
  logic [SIZE_DW-1:0]   iw_wdata  [2];
  logic                 iw_is48   [2];
  logic [SIZE_DW-1:0]   ow_rdata  [2];
  logic                 ow_oob    [2];
  logic                 ow_ready;

  modport master (
    output iw_addr_v, iw_addr, iw_we,
    output iw_wdata, iw_is48,
    input  ow_rdata, ow_oob, ow_ready
  );

  modport slave (
    input  iw_addr_v, iw_addr, iw_we,
    input  iw_wdata, iw_is48,
    output ow_rdata, ow_oob, ow_ready
  );

endinterface

// File: rtl/mem_dp48_port_ctl.sv
// mem_dp48 per-port control: MA address latch, range check,
// and MO write lane enables.
module mem_dp48_port_ctl
  import mem_dp48_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic                  addr_v,
  input  logic [SIZE_ADDR-1:0]  addr,
  input  logic                  we,
  input  logic                  is48,
  input  logic                  ready,
  output logic [DEPTH_LOG2-1:0] idx,
  output logic [DEPTH_LOG2-1:0] idx_hi,
  output logic                  oob,
  output wr_lane_t              lane
);

  logic [SIZE_ADDR-1:0] r_addr;

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      r_addr <= '0;
    end else if (addr_v) begin
      r_addr <= addr;
    end
  end

  assign idx    = r_addr[DEPTH_LOG2-1:0];
  assign idx_hi = idx + DEPTH_LOG2'(1);

  // A 48-bit span never wraps past the top word.
  assign oob = (|r_addr[SIZE_ADDR-1:DEPTH_LOG2])
             | (is48 & (&idx));

  assign lane.lo = we & ready & ~oob;
  assign lane.hi = we & ready & ~oob & is48;

endmodule

// File: rtl/mem_dp48.sv
// mem_dp48: dual-port 24-bit word memory with 48-bit packed
// accesses and a post-reset zeroing sweep.
module mem_dp48
  import mem_dp48_pkg::*;
#(
  parameter int DEPTH_LOG2     = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic       iw_clk,
  input logic       iw_rst,
  mem_dp48_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] LAST = '1;
  localparam mem_st_e ST_RST =
    CLEAR_ON_RESET ? MEM_ST_CLR : MEM_ST_RUN;
  localparam int PW = MEM_WR_PRIO;
  localparam int PL = 1 - MEM_WR_PRIO;

  logic [SIZE_WORD-1:0] mem [DEPTH];

  mem_st_e               st_q, st_d;
  logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
  logic                  ready;

  logic [DEPTH_LOG2-1:0] idx    [2];
  logic [DEPTH_LOG2-1:0] idx_hi [2];
  logic                  oob    [2];
  wr_lane_t              lane   [2];

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      st_q  <= ST_RST;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      MEM_ST_CLR: begin
        cnt_d = cnt_q + DEPTH_LOG2'(1);
        if (cnt_q == LAST) st_d = MEM_ST_RUN;
      end
      MEM_ST_RUN: ;
      default: st_d = ST_RST;
    endcase
  end

  assign ready        = (st_q == MEM_ST_RUN);
  assign bus.ow_ready = ready;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [SIZE_DW-1:0] rd;

    mem_dp48_port_ctl #(
      .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ctl (
      .iw_clk (iw_clk),
      .iw_rst (iw_rst),
      .addr_v (bus.iw_addr_v[p]),
      .addr   (bus.iw_addr[p]),
      .we     (bus.iw_we[p]),
      .is48   (bus.iw_is48[p]),
      .ready  (ready),
      .idx    (idx[p]),
      .idx_hi (idx_hi[p]),
      .oob    (oob[p]),
      .lane   (lane[p])
    );

    always_comb begin
      rd = '0;
      if (ready && !oob[p]) begin
        if (bus.iw_is48[p]) begin
          rd = pack48(mem[idx_hi[p]], mem[idx[p]]);
        end else begin
          rd = pack48('0, mem[idx[p]]);
        end
      end
    end

    assign bus.ow_rdata[p] = rd;
    assign bus.ow_oob[p]   = ready & oob[p];
  end

  // Later assignment wins, so the priority port goes last.
  always_ff @(posedge iw_clk) begin
    if (!iw_rst) begin
      if (st_q == MEM_ST_CLR) mem[cnt_q] <= '0;
      if (lane[PL].lo)
        mem[idx[PL]] <= bus.iw_wdata[PL][SIZE_WORD-1:0];
      if (lane[PL].hi)
        mem[idx_hi[PL]] <= bus.iw_wdata[PL][SIZE_DW-1:SIZE_WORD];
      if (lane[PW].lo)
        mem[idx[PW]] <= bus.iw_wdata[PW][SIZE_WORD-1:0];
      if (lane[PW].hi)
        mem[idx_hi[PW]] <= bus.iw_wdata[PW][SIZE_DW-1:SIZE_WORD];
    end
  end

endmodule

// File: doc/mem_dp48.md
Name: mem_dp48

Overview:
- Dual-port, 24-bit-word data memory that responds to the pipeline's MA/MO memory-port protocol.
- MA stage latches an address on one port in cycle N. The MO stage reads or writes that same port in cycle N+1, while MA uses the opposite port.
- Each port supports 24-bit or 48-bit accesses. 48-bit accesses are packed and unpacked little-endian across two adjacent words.
- A post-reset clear sequencer zeroes the array before the port goes ready.

Parameters:
- DEPTH_LOG2, 12, log2 of the number of 24-bit words.
- CLEAR_ON_RESET, 1, 1 = sweep the array to zero after reset; 0 = ready immediately.

Ports:
- iw_clk  in  1  clock.
- iw_rst  in  1  reset, asynchronous, active-high.
- iw_addr_v [0:1]  in  1 each  MA address-valid, per port.
- iw_addr [0:1]  in  `SIZE_ADDR (48) each  MA word address, per port.
- iw_we [0:1]  in  1 each  MO write enable, per port.
- iw_wdata [0:1]  in  48 each  MO write data; the low 24 bits are used when is48=0.
- iw_is48 [0:1]  in  1 each  access width, 1 = 48-bit.
- ow_rdata [0:1]  out  48 each  read data for the latched address.
- ow_oob [0:1]  out  1 each  latched address out of range for the current width.
- ow_ready  out  1  clear complete, array usable.

Behaviour:
- Reset values:
  - address registers r_addr[0:1] = 0.
  - clear counter = 0.
  - state = CLR if CLEAR_ON_RESET else RUN.
  - ow_ready = 0 (1 if CLEAR_ON_RESET=0).
  - ow_rdata and ow_oob are combinational; both are 0 while not ready.
  - The array itself is not reset.
- Address latch:
  - On posedge, r_addr[p] <= iw_addr[p] only when iw_addr_v[p]=1; otherwise it holds.
  - Ports are independent. Both ports may latch in the same cycle.
- Index and range, with a = r_addr[p][DEPTH_LOG2-1:0]:
  - oob = (r_addr[p][47:DEPTH_LOG2] != 0), or (iw_is48[p] and a == DEPTH-1).
  - A 48-bit access does not wrap.
- Read, combinational from r_addr and iw_is48 in the same cycle (zero added latency relative to the MO cycle):
  - is48=1: ow_rdata = {mem[a+1], mem[a]}.
  - is48=0: ow_rdata = {24'b0, mem[a]}.
  - oob or not ready: ow_rdata = 0.
- Write, at the posedge ending the MO cycle, when iw_we[p] and ready and not oob:
  - mem[a] <= wdata[23:0].
  - If is48, also mem[a+1] <= wdata[47:24].
  - An oob write is dropped, and ow_oob is visible during that cycle.
- Read-during-write, same port and cycle: the read returns the old contents. The new value is visible from the next cycle on either port.
- Both ports writing the same word in the same cycle: port 1 wins, per word. This includes partial overlap of 48-bit spans.
- FSM:
  - CLR: writes mem[cnt] <= 0 and increments cnt each cycle. At cnt == DEPTH-1 it moves to RUN, with ow_ready=1 from the next cycle.
  - Clear takes DEPTH cycles.
  - Port writes are ignored in CLR. Address latching still operates.
  - RUN: normal operation, terminal state.
- Reset asserted mid-clear or mid-operation restarts CLR at index 0. A write in flight in that cycle is lost.

Decomposition:
- Add to src/sizes.vh: SIZE_WORD 24 (reuse SIZE_DATA), SIZE_ADDR 48.
- Add a shared header src/mem.vh: state encodings MEM_ST_CLR/MEM_ST_RUN, and the per-word write-merge priority constant.
- One natural sub-module: mem_port_ctl. It holds the per-port address register, the oob computation and the write-enable/lane generation, and is instantiated twice. The top level holds the array, the write arbitration and the clear FSM.

Test Plan:
- Clear:
  - Reset with CLEAR_ON_RESET=1, DEPTH_LOG2=4 -> ow_ready=0 for 16 cycles, then 1.
  - Every index then reads 0 (after pre-seeding 0xABCDEF through a testbench backdoor).
- 24-bit round trip:
  - MA port0 addr=5 (v=1); next cycle MO port0 we=1, wdata=0x123456.
  - Then MA port1 addr=5; next cycle port1 is48=0 -> rdata = 0x000000123456.
- 48-bit packing:
  - Write is48 at addr 8 with wdata 0xAAAAAA_BBBBBB.
  - 24-bit reads of addr 8 and addr 9 -> 0xBBBBBB and 0xAAAAAA.
  - A 48-bit read of addr 8 -> 0xAAAAAABBBBBB.
- Alternation and hold:
  - Interleave MA/MO on opposite ports for 20 cycles with random addresses and data, with addr_v=0 on the MO port.
  - Every read matches the scoreboard, and the held addresses are unchanged.
- Boundaries:
  - is48 access at addr 15 (DEPTH 16) -> oob=1, rdata=0, write dropped.
  - addr 0x10 -> oob=1.
  - 24-bit access at addr 15 -> oob=0.
- Conflicts:
  - Same-cycle writes: port0 48-bit at addr 3 with 0x111111_222222, port1 24-bit at addr 4 with 0x333333.
  - Result: mem[3]=0x222222, mem[4]=0x333333.
  - Same-port read-during-write returns the old value.
  - Reset asserted at clear cycle 7 -> clear restarts, ready only after 16 more cycles.
